fp_div_iter: RTL and testbench
==============================

// Module: fp_div_iter
// PURPOSE
//  Parametrised iterative floating-point divider; defaults to bfloat16 (EXP_W=8, MAN_W=7).
//  Radix-2 restoring mantissa division, one quotient bit per cycle.
//  Full IEEE-style special-case handling, round-to-nearest-even, exception flags.
//  Valid/ready on both sides, one operation in flight; sits in the bfloat arithmetic unit.
// PARAMETERS
//  EXP_W   8  exponent field width; BIAS = 2**(EXP_W-1)-1
//  MAN_W   7  stored mantissa (fraction) width; word width W = 1+EXP_W+MAN_W
//  RNE_EN  1  1: round-to-nearest-even; 0: truncate (round toward zero)
// PORTS
//  clk        in   1   rising-edge clock
//  rst_n      in   1   asynchronous active-low reset
//  in_valid   in   1   operand pair valid
//  in_ready   out  1   block can accept operands (high only in IDLE)
//  a          in   W   dividend {sign, exp, frac}
//  b          in   W   divisor {sign, exp, frac}
//  out_valid  out  1   result valid, held until out_ready
//  out_ready  in   1   downstream accepts result
//  c          out  W   quotient
//  flags      out  5   {invalid, div_by_zero, overflow, underflow, inexact}, same timing as c
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, out_valid=0, c=0, flags=0, datapath regs=0.
//   In-flight op discarded; no result emitted.
//  in_ready = (state==IDLE). Accept on posedge with in_valid&&in_ready; a/b registered.
//  FSM: IDLE -> CALC on accept (normal operands); IDLE -> DONE on accept (special case).
//   CALC -> NORM after N=MAN_W+3 iterations; NORM -> DONE; DONE -> IDLE on out_ready.
//  Latency, accept edge T: special case out_valid at T+1; normal out_valid at T+N+2 (bf16: T+12).
//  c/flags stable while out_valid && !out_ready; no accept in the DONE cycle.
//  Inputs with exp==0 are zero (subnormals flushed, sign kept); sign_c = sa^sb in every case.
//  Special-case priority, first match wins:
//   any NaN operand          -> qNaN {0, all-ones, 1<<(MAN_W-1)}; invalid=1 only for sNaN
//   0/0 or inf/inf           -> same qNaN, invalid=1
//   inf/x                    -> signed inf
//   x/0, x finite nonzero    -> signed inf, div_by_zero=1
//   0/x or x/inf             -> signed zero
//  Normal path:
//   exponent in EXP_W+2-bit signed: e = ea - eb + BIAS
//   mantissas {1,frac}; restoring division yields N quotient bits (q in (0.5,2))
//   q<1: shift left 1, e-=1; keep MAN_W frac bits, guard, round; sticky = |remainder
//   RNE: increment if G&&(R||S||lsb); mantissa carry-out -> frac=0, e+=1
//   e >= 2**EXP_W-1 -> signed inf, overflow=1, inexact=1
//   e <= 0 -> signed zero, underflow=1, inexact=1 (no subnormal output)
//   inexact = G|R|S on normal results
// TESTING
//  a=0x40C0 (6.0), b=0x4000 (2.0) -> c=0x4040 (3.0), flags=0, out_valid exactly 12 cycles after accept.
//  a=0x3F80, b=0x4040 (1/3) -> c=0x3EAB (round-up), inexact=1; RNE_EN=0 -> c=0x3EAA.
//  a=0xC0C0 (-6.0), b=0x4000 -> c=0xC040; a=0x3F80, b=0x8000 -> c=0xFF80, div_by_zero=1, latency 1.
//  Specials:
//   0/0 -> 0x7FC0, invalid=1
//   0x7F7F / 0x3F00 -> 0x7F80, overflow=1, inexact=1
//   0x0080 / 0x4000 -> 0x0000, underflow=1, inexact=1
//  Handshake:
//   out_ready low 5 cycles after out_valid -> c/flags hold, in_ready=0
//   out_ready high -> IDLE next cycle
//  Reset mid-CALC (rst_n low 1 cycle):
//   out_valid=0, c=0 immediately; in_ready=1 after release
//   next op 6.0/2.0 returns 0x4040

Source files
------------

// File: rtl/fp_div_iter.sv
`default_nettype none
// ============================================================================
//  Module      : fp_div_iter
//  Description : Iterative floating-point divider (bfloat16 by default).
//                Radix-2 restoring mantissa division, one quotient bit per
//                cycle, IEEE-style special cases, RNE or truncation,
//                exception flags, valid/ready on both sides.
//  Revision    : 1.0  initial release
// ============================================================================
module fp_div_iter #(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 7,
    parameter int RNE_EN = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   c,
    output logic [4:0]             flags
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int N    = MAN_W + 3;          // quotient bits produced
    localparam int EW   = EXP_W + 2;          // signed working exponent width
    localparam int RW   = MAN_W + 2;          // partial remainder width
    localparam int CW   = $clog2(N + 1);
    localparam int BIAS = 2**(EXP_W-1) - 1;

    localparam logic [EXP_W-1:0]    EXP_ONES = {EXP_W{1'b1}};
    localparam logic signed [EW-1:0] EMAX    = EW'((2**EXP_W) - 1);
    localparam logic signed [EW-1:0] EZERO   = '0;
    // Canonical quiet NaN is returned with a positive sign.
    localparam logic [W-1:0]        QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_NORM = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic                   sign_q, sign_d;
    logic signed [EW-1:0]   exp_q, exp_d;
    logic [MAN_W:0]         mb_q, mb_d;
    logic [RW-1:0]          rem_q, rem_d;
    logic [N-1:0]           quo_q, quo_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [W-1:0]           c_q, c_d;
    logic [4:0]             flags_q, flags_d;

    // Operand field decode
    logic                   w_sa, w_sb, w_sign;
    logic [EXP_W-1:0]       w_ea, w_eb;
    logic [MAN_W-1:0]       w_fa, w_fb;
    logic                   w_a_zero, w_b_zero, w_a_inf, w_b_inf;
    logic                   w_a_nan, w_b_nan, w_a_snan, w_b_snan;
    logic signed [EW-1:0]   w_exp0;

    assign {w_sa, w_ea, w_fa} = a;
    assign {w_sb, w_eb, w_fb} = b;
    assign w_sign   = w_sa ^ w_sb;
    assign w_a_zero = (w_ea == '0);
    assign w_b_zero = (w_eb == '0);
    assign w_a_inf  = (w_ea == EXP_ONES) && (w_fa == '0);
    assign w_b_inf  = (w_eb == EXP_ONES) && (w_fb == '0);
    assign w_a_nan  = (w_ea == EXP_ONES) && (w_fa != '0);
    assign w_b_nan  = (w_eb == EXP_ONES) && (w_fb != '0);
    assign w_a_snan = w_a_nan && !w_fa[MAN_W-1];
    assign w_b_snan = w_b_nan && !w_fb[MAN_W-1];
    assign w_exp0   = EW'(w_ea) - EW'(w_eb) + EW'(BIAS);

    // Special-case result selection, first matching rule wins
    logic           w_special;
    logic [W-1:0]   w_spec_c;
    logic [4:0]     w_spec_f;

    always_comb begin
        w_special = 1'b1;
        w_spec_c  = '0;
        w_spec_f  = '0;
        if (w_a_nan || w_b_nan) begin
            w_spec_c    = QNAN;
            w_spec_f[4] = w_a_snan || w_b_snan;
        end else if ((w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            w_spec_c    = QNAN;
            w_spec_f[4] = 1'b1;
        end else if (w_a_inf) begin
            w_spec_c    = {w_sign, EXP_ONES, {MAN_W{1'b0}}};
        end else if (w_b_zero) begin
            w_spec_c    = {w_sign, EXP_ONES, {MAN_W{1'b0}}};
            w_spec_f[3] = 1'b1;
        end else if (w_a_zero || w_b_inf) begin
            w_spec_c    = {w_sign, {(W-1){1'b0}}};
        end else begin
            w_special   = 1'b0;
        end
    end

    // One restoring-division step: compare, conditionally subtract, shift
    logic           w_ge;
    logic [RW-1:0]  w_rem_sub, w_rem_next;

    assign w_ge       = (rem_q >= {1'b0, mb_q});
    assign w_rem_sub  = w_ge ? (rem_q - {1'b0, mb_q}) : rem_q;
    assign w_rem_next = {w_rem_sub[RW-2:0], 1'b0};

    // Normalise, round and range-check the finished quotient
    logic [MAN_W-1:0]       w_frac_t;
    logic                   w_g, w_r, w_s, w_inc;
    logic [MAN_W:0]         w_sum;
    logic signed [EW-1:0]   w_e_n, w_e_r;
    logic [W-1:0]           w_norm_c;
    logic [4:0]             w_norm_f;

    always_comb begin
        w_frac_t = '0;
        w_g      = 1'b0;
        w_r      = 1'b0;
        w_e_n    = exp_q;
        if (quo_q[N-1]) begin
            w_frac_t = quo_q[N-2 -: MAN_W];
            w_g      = quo_q[1];
            w_r      = quo_q[0];
        end else begin
            // quotient below 1: one extra position of precision, exponent drops
            w_frac_t = quo_q[N-3 -: MAN_W];
            w_g      = quo_q[0];
            w_e_n    = exp_q - EW'(1);
        end
        w_s      = |rem_q;
        w_inc    = (RNE_EN != 0) && w_g && (w_r || w_s || w_frac_t[0]);
        w_sum    = {1'b0, w_frac_t} + {{MAN_W{1'b0}}, w_inc};
        w_e_r    = w_sum[MAN_W] ? (w_e_n + EW'(1)) : w_e_n;
        if (w_e_r >= EMAX) begin
            w_norm_c = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
            w_norm_f = 5'b00101;
        end else if (w_e_r <= EZERO) begin
            w_norm_c = {sign_q, {(W-1){1'b0}}};
            w_norm_f = 5'b00011;
        end else begin
            w_norm_c = {sign_q, w_e_r[EXP_W-1:0], w_sum[MAN_W-1:0]};
            w_norm_f = {4'b0000, w_g | w_r | w_s};
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        mb_d    = mb_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        flags_d = flags_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sign_d = w_sign;
                    exp_d  = w_exp0;
                    mb_d   = {1'b1, w_fb};
                    rem_d  = {1'b0, 1'b1, w_fa};
                    quo_d  = '0;
                    cnt_d  = '0;
                    if (w_special) begin
                        c_d     = w_spec_c;
                        flags_d = w_spec_f;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                rem_d = w_rem_next;
                quo_d = {quo_q[N-2:0], w_ge};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                c_d     = w_norm_c;
                flags_d = w_norm_f;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q  <= 1'b0;
            exp_q   <= '0;
            mb_q    <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            c_q     <= '0;
            flags_q <= '0;
        end else begin
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            mb_q    <= mb_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            flags_q <= flags_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign c         = c_q;
    assign flags     = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_div_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_div_iter
//  Description : Self-checking bench for fp_div_iter (bfloat16, RNE and
//                truncating instances driven in lockstep).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fp_div_iter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] a = '0, b = '0;
    logic        in_ready, out_valid, in_ready_t, out_valid_t;
    logic [15:0] c, c_t;
    logic [4:0]  flags, flags_t;

    fp_div_iter #(.EXP_W(8), .MAN_W(7), .RNE_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .c(c), .flags(flags)
    );

    fp_div_iter #(.EXP_W(8), .MAN_W(7), .RNE_EN(0)) dut_t (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_t),
        .a(a), .b(b), .out_valid(out_valid_t), .out_ready(out_ready),
        .c(c_t), .flags(flags_t)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference: exact integer division, then normalise and round.
    // Returns {flags[4:0], c[15:0]}.
    function automatic logic [20:0] model(input logic [15:0] x, input logic [15:0] y, input bit rne);
        bit s = x[15] ^ y[15];
        int ex = int'(x[14:7]);
        int ey = int'(y[14:7]);
        int fx = int'(x[6:0]);
        int fy = int'(y[6:0]);
        bit nx = (ex == 255) && (fx != 0);
        bit ny = (ey == 255) && (fy != 0);
        bit ix = (ex == 255) && (fx == 0);
        bit iy = (ey == 255) && (fy == 0);
        bit zx = (ex == 0);
        bit zy = (ey == 0);
        longint num, q, r, low, half;
        int e, mant;
        bit inexact;
        if (nx || ny)
            return {(nx && x[6] == 1'b0) || (ny && y[6] == 1'b0), 4'b0000, 16'h7FC0};
        if ((zx && zy) || (ix && iy))
            return {5'b10000, 16'h7FC0};
        if (ix)
            return {5'b00000, s, 8'hFF, 7'h00};
        if (zy)
            return {5'b01000, s, 8'hFF, 7'h00};
        if (zx || iy)
            return {5'b00000, s, 15'h0000};
        e   = ex - ey + 127;
        num = longint'(128 + fx) <<< 16;
        q   = num / (128 + fy);
        r   = num % (128 + fy);
        if (q >= 65536) begin
            mant = int'(q >>> 9); low = q & 511; half = 256;
        end else begin
            e = e - 1;
            mant = int'(q >>> 8); low = q & 255; half = 128;
        end
        inexact = (low != 0) || (r != 0);
        if (rne && ((low > half) || (low == half && (r != 0 || mant % 2 == 1))))
            mant = mant + 1;
        if (mant == 256) begin
            mant = 128; e = e + 1;
        end
        if (e >= 255)
            return {5'b00101, s, 8'hFF, 7'h00};
        if (e <= 0)
            return {5'b00011, s, 15'h0000};
        return {4'b0000, inexact, s, e[7:0], mant[6:0]};
    endfunction

    function automatic bit is_special(input logic [15:0] x, input logic [15:0] y);
        return (x[14:7] == 8'h00) || (x[14:7] == 8'hFF) || (y[14:7] == 8'h00) || (y[14:7] == 8'hFF);
    endfunction

    // Accept / handshake monitor
    int          cyc = 0, acc_cyc = 0, acc_id = 0, hs_cnt = 0;
    bit          pend = 1'b0;
    logic [15:0] pa = '0, pb = '0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            pend = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                pend = 1'b0;
                hs_cnt = hs_cnt + 1;
            end
            if (in_valid && in_ready) begin
                pend = 1'b1; pa = a; pb = b;
                acc_cyc = cyc; acc_id = acc_id + 1;
            end
        end
    end

    // Directed expectations posted by the stimulus process
    bit          dir_on = 1'b0;
    logic [15:0] dir_c = '0, dir_ct = '0;
    logic [4:0]  dir_f = '0;
    int          dir_lat = 0;
    int          tmo_cnt = 0;

    // Compare process: every check of the bench lives here
    int          hs_seen = 0, lat_id = 0, tmo_seen = 0, lat, exp_lat;
    logic [20:0] m_r, m_t;

    always @(negedge clk) begin
        if (tmo_cnt != tmo_seen) begin
            tmo_seen = tmo_cnt;
            checks++; errors++;
            $display("FAIL timeout: wait bound expired (count %0d)", tmo_cnt);
        end
        if (!rst_n) begin
            checks++;
            if (out_valid !== 1'b0 || c !== 16'h0 || flags !== 5'h0 || in_ready !== 1'b1 ||
                out_valid_t !== 1'b0 || c_t !== 16'h0)
                begin errors++; $display("FAIL reset_state: out_valid=%b c=%h flags=%b in_ready=%b, want 0 0000 00000 1",
                                         out_valid, c, flags, in_ready); end
        end else begin
            if (hs_cnt != hs_seen) begin
                hs_seen = hs_cnt;
                checks++;
                if (out_valid !== 1'b0 || in_ready !== 1'b1)
                    begin errors++; $display("FAIL after_handshake: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready); end
            end
            if (out_valid === 1'b1 || out_valid_t === 1'b1) begin
                checks++;
                if (!pend) begin
                    errors++; $display("FAIL spurious_valid: out_valid=%b with no operation in flight", out_valid);
                end else begin
                    m_r = model(pa, pb, 1'b1);
                    m_t = model(pa, pb, 1'b0);
                    if ({out_valid, flags, c} !== {1'b1, m_r})
                        begin errors++; $display("FAIL result_rne %h/%h: got c=%h flags=%b, want c=%h flags=%b",
                                                 pa, pb, c, flags, m_r[15:0], m_r[20:16]); end
                    checks++;
                    if ({out_valid_t, flags_t, c_t} !== {1'b1, m_t})
                        begin errors++; $display("FAIL result_trunc %h/%h: got c=%h flags=%b, want c=%h flags=%b",
                                                 pa, pb, c_t, flags_t, m_t[15:0], m_t[20:16]); end
                    checks++;
                    if (in_ready !== 1'b0)
                        begin errors++; $display("FAIL ready_in_done: in_ready=%b, want 0", in_ready); end
                    if (acc_id != lat_id) begin
                        lat_id  = acc_id;
                        lat     = cyc - acc_cyc + 1;
                        exp_lat = is_special(pa, pb) ? 1 : 12;
                        checks++;
                        if (lat != exp_lat)
                            begin errors++; $display("FAIL latency %h/%h: got %0d, want %0d", pa, pb, lat, exp_lat); end
                        if (dir_on) begin
                            checks++;
                            if (c !== dir_c || flags !== dir_f)
                                begin errors++; $display("FAIL directed %h/%h: got c=%h flags=%b, want c=%h flags=%b",
                                                         pa, pb, c, flags, dir_c, dir_f); end
                            checks++;
                            if (c_t !== dir_ct)
                                begin errors++; $display("FAIL directed_trunc %h/%h: got c=%h, want c=%h", pa, pb, c_t, dir_ct); end
                            checks++;
                            if (lat != dir_lat)
                                begin errors++; $display("FAIL directed_latency %h/%h: got %0d, want %0d", pa, pb, lat, dir_lat); end
                        end
                    end
                end
            end
        end
    end

    // One operation: present operands, wait for result, hold out_ready low dly cycles
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tbv, input int dly);
        int n;
        out_ready = (dly == 0);
        a = ta; b = tbv; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        if (!in_ready) tmo_cnt++;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 40) begin @(negedge clk); n++; end
        if (!out_valid) tmo_cnt++;
        repeat (dly) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_dir(input logic [15:0] ta, input logic [15:0] tbv, input logic [15:0] ec,
                           input logic [4:0] ef, input logic [15:0] ect, input int el, input int dly);
        dir_c = ec; dir_f = ef; dir_ct = ect; dir_lat = el; dir_on = 1'b1;
        run_op(ta, tbv, dly);
        dir_on = 1'b0;
    endtask

    function automatic logic [15:0] rand_operand();
        int sel = $urandom_range(0, 15);
        logic [15:0] v = 16'($urandom);
        case (sel)
            0:       v[14:7] = 8'h00;
            1:       begin v[14:7] = 8'hFF; v[6:0] = 7'h00; end
            2:       begin v[14:7] = 8'hFF; if (v[6:0] == 7'h00) v[0] = 1'b1; end
            3:       v[14:7] = 8'($urandom_range(1, 12));
            4:       v[14:7] = 8'($urandom_range(243, 254));
            5:       begin v[14:7] = 8'($urandom_range(110, 140)); v[3:0] = 4'h0; end
            default: v[14:7] = 8'($urandom_range(90, 165));
        endcase
        return v;
    endfunction

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        run_dir(16'h40C0, 16'h4000, 16'h4040, 5'b00000, 16'h4040, 12, 0);
        run_dir(16'h3F80, 16'h4040, 16'h3EAB, 5'b00001, 16'h3EAA, 12, 0);
        run_dir(16'hC0C0, 16'h4000, 16'hC040, 5'b00000, 16'hC040, 12, 0);
        run_dir(16'h3F80, 16'h8000, 16'hFF80, 5'b01000, 16'hFF80, 1, 0);
        run_dir(16'h0000, 16'h0000, 16'h7FC0, 5'b10000, 16'h7FC0, 1, 0);
        run_dir(16'h7F7F, 16'h3F00, 16'h7F80, 5'b00101, 16'h7F80, 12, 0);
        run_dir(16'h0080, 16'h4000, 16'h0000, 5'b00011, 16'h0000, 12, 0);
        run_dir(16'h7F81, 16'h3F80, 16'h7FC0, 5'b10000, 16'h7FC0, 1, 0);
        // result held while downstream stalls
        run_dir(16'h40C0, 16'h4000, 16'h4040, 5'b00000, 16'h4040, 12, 5);

        // reset in the middle of an iteration
        a = 16'h3F80; b = 16'h4040; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        run_dir(16'h40C0, 16'h4000, 16'h4040, 5'b00000, 16'h4040, 12, 0);

        for (int i = 0; i < 300; i++) begin
            run_op(rand_operand(), rand_operand(), ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0);
        end

        @(negedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
